imuldiv_muldiv_req_queue: RTL and testbench

IMULDIV_MULDIV_REQ_QUEUE -- requirements
Module: imuldiv_MulDivReqQueue

---
 rtl/imuldiv_muldiv_req_queue.sv | 98 +++++++++
 tb/tb_imuldiv_muldiv_req_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imuldiv_muldiv_req_queue.sv
// Request queue in front of the iterative mul/div unit: a DEPTH-entry circular
// buffer with valid/ready handshakes on both sides and no enqueue-to-dequeue bypass.

package imuldiv_muldiv_req_queue_pkg;

  localparam int unsigned FN_W   = 3;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [FN_W-1:0]   fn;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } muldiv_req_t;

endpackage

module imuldiv_muldiv_req_queue
  import imuldiv_muldiv_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               enq_msg_fn,
  input  logic [31:0]              enq_msg_a,
  input  logic [31:0]              enq_msg_b,
  input  logic                     enq_val,
  output logic                     enq_rdy,
  output logic [2:0]               deq_msg_fn,
  output logic [31:0]              deq_msg_a,
  output logic [31:0]              deq_msg_b,
  output logic                     deq_val,
  input  logic                     deq_rdy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  muldiv_req_t             mem [DEPTH];
  muldiv_req_t             enq_req_c;
  muldiv_req_t             deq_req_c;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    enq_go_c;
  logic                    deq_go_c;
  logic [CNT_W-1:0]        count_next_c;

  assign enq_go_c = enq_val & enq_rdy;
  assign deq_go_c = deq_val & deq_rdy;

  assign enq_req_c = '{fn: enq_msg_fn, a: enq_msg_a, b: enq_msg_b};

  // Occupancy only moves when exactly one side transfers.
  always_comb begin
    count_next_c = count;
    unique case ({enq_go_c, deq_go_c})
      2'b10:   count_next_c = count + CNT_W'(1);
      2'b01:   count_next_c = count - CNT_W'(1);
      default: count_next_c = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq_go_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_go_c) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Handshake flags are registered alongside count so neither depends on deq_rdy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      enq_rdy <= 1'b1;
      deq_val <= 1'b0;
    end else begin
      count   <= count_next_c;
      enq_rdy <= (count_next_c != CNT_W'(DEPTH));
      deq_val <= (count_next_c != '0);
    end
  end

  // Payload storage carries no reset; contents are only observed while deq_val is high.
  always_ff @(posedge clk) begin
    if (enq_go_c) mem[wr_ptr] <= enq_req_c;
  end

  assign deq_req_c  = mem[rd_ptr];
  assign deq_msg_fn = deq_req_c.fn;
  assign deq_msg_a  = deq_req_c.a;
  assign deq_msg_b  = deq_req_c.b;

endmodule

// File: tb/tb_imuldiv_muldiv_req_queue.sv
// Directed bench for imuldiv_muldiv_req_queue at DEPTH = 4 with hand-computed expectations.

module tb_imuldiv_muldiv_req_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  enq_msg_fn;
  logic [31:0] enq_msg_a;
  logic [31:0] enq_msg_b;
  logic        enq_val;
  logic        enq_rdy;
  logic [2:0]  deq_msg_fn;
  logic [31:0] deq_msg_a;
  logic [31:0] deq_msg_b;
  logic        deq_val;
  logic        deq_rdy;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  imuldiv_muldiv_req_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enq_msg_fn (enq_msg_fn),
    .enq_msg_a  (enq_msg_a),
    .enq_msg_b  (enq_msg_b),
    .enq_val    (enq_val),
    .enq_rdy    (enq_rdy),
    .deq_msg_fn (deq_msg_fn),
    .deq_msg_a  (deq_msg_a),
    .deq_msg_b  (deq_msg_b),
    .deq_val    (deq_val),
    .deq_rdy    (deq_rdy),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    enq_val    = v;
    enq_msg_fn = fn;
    enq_msg_a  = a;
    enq_msg_b  = b;
  endtask

  initial begin
    reset   = 1'b0;
    deq_rdy = 1'b0;
    set_enq(1'b0, 3'd0, 32'd0, 32'd0);
    step();
    step();
    chk("rst_count",   32'(count),   32'd0);
    chk("rst_enq_rdy", 32'(enq_rdy), 32'd1);
    chk("rst_deq_val", 32'(deq_val), 32'd0);
    reset = 1'b1;

    // Single pass: mul 3*4, accepted on the first edge after reset.
    set_enq(1'b1, 3'd0, 32'h0000_0003, 32'h0000_0004);
    deq_rdy = 1'b1;
    chk("sp_deq_val_pre", 32'(deq_val), 32'd0);
    step();
    chk("sp_deq_val", 32'(deq_val),    32'd1);
    chk("sp_count1",  32'(count),      32'd1);
    chk("sp_fn",      32'(deq_msg_fn), 32'd0);
    chk("sp_a",       deq_msg_a,       32'h3);
    chk("sp_b",       deq_msg_b,       32'h4);
    set_enq(1'b0, 3'd7, 32'hdead_beef, 32'hdead_beef);
    step();
    chk("sp_count0",   32'(count),   32'd0);
    chk("sp_deq_val0", 32'(deq_val), 32'd0);
    step();
    chk("empty_deq_rdy_ignored", 32'(count), 32'd0);

    // Fill with a = 1..5 while the consumer stalls.
    deq_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_enq(1'b1, 3'd1, 32'(i), 32'(i + 100));
      step();
      chk($sformatf("fill_count_%0d", i), 32'(count), (i > 4) ? 32'd4 : 32'(i));
      chk($sformatf("fill_enq_rdy_%0d", i), 32'(enq_rdy), (i >= 4) ? 32'd0 : 32'd1);
      chk($sformatf("fill_head_stable_%0d", i), deq_msg_a, 32'd1);
    end

    // Drain from full: heads 1..4 on consecutive cycles.
    set_enq(1'b0, 3'd0, 32'd0, 32'd0);
    deq_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain_val_%0d", k), 32'(deq_val), 32'd1);
      chk($sformatf("drain_a_%0d", k), deq_msg_a, 32'(k));
      chk($sformatf("drain_b_%0d", k), deq_msg_b, 32'(k + 100));
      step();
    end
    chk("drain_deq_val0", 32'(deq_val), 32'd0);
    chk("drain_count0",   32'(count),   32'd0);

    // Full plus dequeue: the freed slot shows up one cycle later.
    deq_rdy = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      set_enq(1'b1, 3'd2, 32'(i), 32'd0);
      step();
    end
    chk("fpd_count_full", 32'(count), 32'd4);
    set_enq(1'b1, 3'd2, 32'd15, 32'd0);
    deq_rdy = 1'b1;
    chk("fpd_enq_rdy_N", 32'(enq_rdy), 32'd0);
    step();
    chk("fpd_enq_rdy_N1", 32'(enq_rdy), 32'd1);
    chk("fpd_count_N1",   32'(count),   32'd3);
    deq_rdy = 1'b0;
    step();
    chk("fpd_count_refill", 32'(count), 32'd4);
    set_enq(1'b0, 3'd0, 32'd0, 32'd0);
    deq_rdy = 1'b1;
    for (int k = 12; k <= 15; k++) begin
      chk($sformatf("fpd_order_%0d", k), deq_msg_a, 32'(k));
      step();
    end
    chk("fpd_empty", 32'(deq_val), 32'd0);

    // Simultaneous enq/deq at count = 2 across pointer wrap.
    deq_rdy = 1'b0;
    for (int i = 20; i <= 21; i++) begin
      set_enq(1'b1, 3'd3, 32'(i), 32'(i));
      step();
    end
    chk("sim_count_start", 32'(count), 32'd2);
    deq_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_enq(1'b1, 3'd3, 32'(22 + k), 32'(22 + k));
      chk($sformatf("sim_head_%0d", k), deq_msg_a, 32'(20 + k));
      step();
      chk($sformatf("sim_count_%0d", k), 32'(count), 32'd2);
    end
    set_enq(1'b0, 3'd0, 32'd0, 32'd0);
    chk("sim_tail_30", deq_msg_a, 32'd30);
    step();
    chk("sim_tail_31", deq_msg_a, 32'd31);
    step();
    chk("sim_empty", 32'(deq_val), 32'd0);

    // Mid-operation reset with three entries stored.
    deq_rdy = 1'b0;
    for (int i = 40; i <= 42; i++) begin
      set_enq(1'b1, 3'd4, 32'(i), 32'd0);
      step();
    end
    set_enq(1'b0, 3'd0, 32'd0, 32'd0);
    chk("mr_count_pre", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_count_now",   32'(count),   32'd0);
    chk("mr_deq_val_now", 32'(deq_val), 32'd0);
    chk("mr_enq_rdy_now", 32'(enq_rdy), 32'd1);
    reset = 1'b1;
    set_enq(1'b1, 3'd4, 32'd50, 32'd51);
    step();
    set_enq(1'b0, 3'd0, 32'd0, 32'd0);
    chk("mr_count_after", 32'(count),   32'd1);
    chk("mr_first_val",   32'(deq_val), 32'd1);
    chk("mr_first_a",     deq_msg_a,    32'd50);
    deq_rdy = 1'b1;
    step();
    chk("mr_no_stale_val", 32'(deq_val), 32'd0);
    chk("mr_count_end",    32'(count),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
